// File: rtl/seg7_display_ctrl.sv
// Four-digit BCD + sign display stage: commits an input frame only after it has held
// steady for STABLE_CYCLES, then drives blanked, PWM-dimmed active-low 7-segment outputs.
//   state  | meaning
//   IDLE   | committed frame matches inputs, waiting for a change
//   SETTLE | candidate captured, counting stable cycles before commit
module seg7_display_ctrl #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16,
  parameter int PWM_BITS      = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [3:0]          digit0,
  input  logic [3:0]          digit1,
  input  logic [3:0]          digit2,
  input  logic [3:0]          digit3,
  input  logic                sign_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [6:0]          hex0,
  output logic [6:0]          hex1,
  output logic [6:0]          hex2,
  output logic [6:0]          hex3,
  output logic [6:0]          hex4,
  output logic                frame_valid
);

  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0]       LP_BLANK    = 7'h7F;
  localparam logic [6:0]       LP_MINUS    = 7'h3F;

  function automatic logic [6:0] f_seg(input logic [3:0] v);
    case (v)
      4'd0:    f_seg = 7'h40;
      4'd1:    f_seg = 7'h79;
      4'd2:    f_seg = 7'h24;
      4'd3:    f_seg = 7'h30;
      4'd4:    f_seg = 7'h19;
      4'd5:    f_seg = 7'h12;
      4'd6:    f_seg = 7'h02;
      4'd7:    f_seg = 7'h78;
      4'd8:    f_seg = 7'h00;
      4'd9:    f_seg = 7'h10;
      default: f_seg = 7'h06;
    endcase
  endfunction

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [16:0]         r_cand, w_cand_nxt;
  logic [16:0]         r_disp;
  logic                r_disp_valid;
  logic                r_frame_valid;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [6:0]          r_hex0, r_hex1, r_hex2, r_hex3, r_hex4;

  logic [16:0] w_in;
  logic        w_commit;
  logic        w_lit;
  logic        w_blank3, w_blank2, w_blank1;
  logic        w_show;

  assign w_in = {sign_in, digit3, digit2, digit1, digit0};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_in != r_cand) begin
          w_cand_nxt  = w_in;
          w_cnt_nxt   = '0;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (w_in != r_cand) begin
          w_cand_nxt = w_in;
          w_cnt_nxt  = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = SETTLE;
    endcase
  end

  // Leading-zero chain runs from the thousands digit down; the units digit always shows.
  assign w_blank3 = (r_disp[15:12] == 4'd0);
  assign w_blank2 = w_blank3 && (r_disp[11:8] == 4'd0);
  assign w_blank1 = w_blank2 && (r_disp[7:4] == 4'd0);

  assign w_lit  = (brightness == {PWM_BITS{1'b1}}) || (r_pwm_cnt < brightness);
  assign w_show = r_disp_valid && w_lit;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state       <= SETTLE;
      r_cnt         <= '0;
      r_cand        <= '0;
      r_disp        <= '0;
      r_disp_valid  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_pwm_cnt     <= '0;
      r_hex0        <= LP_BLANK;
      r_hex1        <= LP_BLANK;
      r_hex2        <= LP_BLANK;
      r_hex3        <= LP_BLANK;
      r_hex4        <= LP_BLANK;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cand        <= w_cand_nxt;
      r_frame_valid <= w_commit;
      r_pwm_cnt     <= r_pwm_cnt + 1'b1;
      if (w_commit) begin
        r_disp       <= r_cand;
        r_disp_valid <= 1'b1;
      end
      r_hex0 <= w_show ? f_seg(r_disp[3:0]) : LP_BLANK;
      r_hex1 <= (w_show && !w_blank1) ? f_seg(r_disp[7:4])   : LP_BLANK;
      r_hex2 <= (w_show && !w_blank2) ? f_seg(r_disp[11:8])  : LP_BLANK;
      r_hex3 <= (w_show && !w_blank3) ? f_seg(r_disp[15:12]) : LP_BLANK;
      r_hex4 <= (w_show && r_disp[16]) ? LP_MINUS : LP_BLANK;
    end
  end

  assign hex0        = r_hex0;
  assign hex1        = r_hex1;
  assign hex2        = r_hex2;
  assign hex3        = r_hex3;
  assign hex4        = r_hex4;
  assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl: a frame-age model checked every cycle, plus directed
// scenarios with hand-computed segment values.
module tb_seg7_display_ctrl;

  localparam int S = 4;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       sign_in;
  logic [3:0] brightness;
  logic [6:0] hex0, hex1, hex2, hex3, hex4;
  logic       frame_valid;

  seg7_display_ctrl #(.STABLE_CYCLES(S), .CNT_W(4), .PWM_BITS(4)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .sign_in(sign_in), .brightness(brightness),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4),
    .frame_valid(frame_valid)
  );

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is committed once a value has been sampled on S+1 consecutive edges.
  logic [6:0]  seg_tab [10];
  logic [16:0] run_val, m_disp;
  int          age, m_edge;
  bit          committed, m_valid, chk_en;
  logic [6:0]  e_hex [5];
  logic        e_fv;

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    chk_en = 0;
  end

  function automatic logic [6:0] m_digit(input logic [3:0] v, input bit blank);
    if (blank) return 7'h7F;
    if (v > 9) return 7'h06;
    return seg_tab[v];
  endfunction

  always @(posedge clk_clk) begin
    logic [16:0] inv;
    logic [3:0]  d [4];
    bit lz3, lz2, lz1, on;
    inv = {sign_in, digit3, digit2, digit1, digit0};
    if (reset_reset) begin
      run_val = '0; age = 1; committed = 0; m_valid = 0; m_disp = '0; m_edge = 0;
      for (int i = 0; i < 5; i++) e_hex[i] = 7'h7F;
      e_fv = 0; chk_en = 1;
    end else begin
      m_edge++;
      on = m_valid && (brightness == 4'hF || ((m_edge - 1) % 16) < int'(brightness));
      for (int i = 0; i < 4; i++) d[i] = m_disp[4*i +: 4];
      lz3 = (d[3] == 0);
      lz2 = lz3 && (d[2] == 0);
      lz1 = lz2 && (d[1] == 0);
      e_hex[0] = m_digit(d[0], !on);
      e_hex[1] = m_digit(d[1], !on || lz1);
      e_hex[2] = m_digit(d[2], !on || lz2);
      e_hex[3] = m_digit(d[3], !on || lz3);
      e_hex[4] = (on && m_disp[16]) ? 7'h3F : 7'h7F;
      if (inv != run_val) begin
        run_val = inv; age = 1; committed = 0;
      end else begin
        age++;
      end
      e_fv = 0;
      if (!committed && age == S + 1) begin
        committed = 1; m_disp = run_val; m_valid = 1; e_fv = 1;
      end
    end
  end

  always @(negedge clk_clk) begin
    if (chk_en) begin
      chk("model_hex0", hex0, e_hex[0]);
      chk("model_hex1", hex1, e_hex[1]);
      chk("model_hex2", hex2, e_hex[2]);
      chk("model_hex3", hex3, e_hex[3]);
      chk("model_hex4", hex4, e_hex[4]);
      chk("model_fv", frame_valid, e_fv);
      if (frame_valid) fv_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_clk);
      #1;
    end
  endtask

  task automatic set_in(input logic s, input logic [3:0] a3, input logic [3:0] a2,
                        input logic [3:0] a1, input logic [3:0] a0);
    sign_in = s; digit3 = a3; digit2 = a2; digit1 = a1; digit0 = a0;
  endtask

  int c0, lit;

  initial begin
    reset_reset = 1; brightness = 4'hF;
    set_in(0, 0, 0, 0, 0);
    tick(3);
    chk("reset_hex0", hex0, 7'h7F);
    chk("reset_hex4", hex4, 7'h7F);
    chk("reset_fv", frame_valid, 0);

    // 1: all zeros commit 4 cycles after release
    reset_reset = 0;
    c0 = fv_cnt;
    tick(3);
    chk("t1_no_early_fv", fv_cnt - c0, 0);
    tick();
    chk("t1_fv_cycle4", frame_valid, 1);
    tick();
    chk("t1_hex0", hex0, 7'h40);
    chk("t1_hex1", hex1, 7'h7F);
    chk("t1_hex3", hex3, 7'h7F);
    chk("t1_hex4", hex4, 7'h7F);
    chk("t1_fv_low", frame_valid, 0);

    // 2: 1205, inner zero stays lit
    set_in(0, 1, 2, 0, 5);
    c0 = fv_cnt;
    tick(4);
    chk("t2_fv_pre", frame_valid, 0);
    tick();
    chk("t2_fv", frame_valid, 1);
    tick();
    chk("t2_hex3", hex3, 7'h79);
    chk("t2_hex2", hex2, 7'h24);
    chk("t2_hex1", hex1, 7'h40);
    chk("t2_hex0", hex0, 7'h12);
    chk("t2_hex4", hex4, 7'h7F);
    tick(2);
    chk("t2_one_pulse", fv_cnt - c0, 1);

    // 3: glitchy writes never commit
    c0 = fv_cnt;
    for (int i = 0; i < 5; i++) begin
      digit0 = (i % 2 == 0) ? 4'd6 : 4'd5;
      tick(3);
    end
    chk("t3_no_commit", fv_cnt - c0, 0);
    tick();
    chk("t3_fv_pre", frame_valid, 0);
    tick();
    chk("t3_fv", frame_valid, 1);
    chk("t3_hex0_old", hex0, 7'h12);
    tick();
    chk("t3_hex0_new", hex0, 7'h02);

    // 4: invalid hundreds digit, negative
    set_in(1, 0, 4'hB, 3, 7);
    tick(6);
    chk("t4_hex3", hex3, 7'h7F);
    chk("t4_hex2", hex2, 7'h06);
    chk("t4_hex1", hex1, 7'h30);
    chk("t4_hex0", hex0, 7'h78);
    chk("t4_hex4", hex4, 7'h3F);

    set_in(0, 0, 0, 7, 0);
    tick(6);
    chk("t4b_hex3", hex3, 7'h7F);
    chk("t4b_hex2", hex2, 7'h7F);
    chk("t4b_hex1", hex1, 7'h78);
    chk("t4b_hex0", hex0, 7'h40);
    chk("t4b_hex4", hex4, 7'h7F);

    // 5: brightness duty
    brightness = 4'd4;
    tick(2);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (hex0 != 7'h7F) lit++;
    end
    chk("t5_duty4", lit, 4);
    brightness = 4'd0;
    tick();
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if ({hex0, hex1, hex2, hex3, hex4} != {5{7'h7F}}) lit++;
    end
    chk("t5_duty0", lit, 0);
    brightness = 4'hF;
    tick(2);
    chk("t5_restore", hex0, 7'h40);

    // 6: reset mid-settle discards the candidate
    set_in(0, 9, 9, 9, 9);
    tick(3);
    reset_reset = 1;
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("t6_hex0", hex0, 7'h7F);
    chk("t6_hex1", hex1, 7'h7F);
    chk("t6_hex3", hex3, 7'h7F);
    chk("t6_fv", frame_valid, 0);
    reset_reset = 0;
    lit = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hex3 != 7'h7F) lit++;
    end
    chk("t6_no_stale", lit, 0);
    chk("t6_final_hex0", hex0, 7'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
